// File: rtl/decimating_boxcar_filter.sv
// Decimating boxcar (moving-window mean) filter: averages 2^LOG2_DECIM accepted
// samples per window and queues each mean in a 2-entry registered output FIFO.
module decimating_boxcar_filter #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_DECIM = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  out_ready,
    output logic [1:0]            buf_level,
    output logic                  overflow,
    input  logic                  clear_ovf
);

    localparam int ACC_W = DATA_WIDTH + LOG2_DECIM;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  mean_full;
    logic [LOG2_DECIM-1:0]    count;
    logic [DATA_WIDTH-1:0]    result;
    logic [DATA_WIDTH-1:0]    tail;
    logic [1:0]               level;
    logic                     accept;
    logic                     push;
    logic                     pop;

    always_comb begin
        accept    = en && data_valid;
        sum       = acc + $signed({{LOG2_DECIM{data_in[DATA_WIDTH-1]}}, data_in});
        // Arithmetic shift gives floor rounding toward minus infinity.
        mean_full = sum >>> LOG2_DECIM;
        result    = mean_full[DATA_WIDTH-1:0];
        push      = accept && (count == '1);
        pop       = (level != 2'd0) && out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (!en) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            if (push) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc   <= sum;
                count <= count + 1'b1;
            end
        end
    end

    // data_out is the FIFO head register itself; tail holds the second entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            tail     <= '0;
            level    <= 2'd0;
        end else begin
            case (level)
                2'd0: begin
                    if (push) begin
                        data_out <= result;
                        level    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        data_out <= result;
                    end else if (push) begin
                        tail  <= result;
                        level <= 2'd2;
                    end else if (pop) begin
                        level <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        data_out <= tail;
                        if (push) begin
                            tail <= result;
                        end else begin
                            level <= 2'd1;
                        end
                    end
                end
                default: level <= 2'd0;
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf wins so no loss goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && (level == 2'd2) && !pop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign data_out_valid = (level != 2'd0);
    assign buf_level      = level;

endmodule

// File: tb/tb_decimating_boxcar_filter.sv
// Directed self-checking bench for decimating_boxcar_filter (default parameters, N = 8).
module tb_decimating_boxcar_filter;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic signed [15:0] data_in;
    logic               data_valid;
    logic signed [15:0] data_out;
    logic               data_out_valid;
    logic               out_ready;
    logic [1:0]         buf_level;
    logic               overflow;
    logic               clear_ovf;

    int tests_run;
    int tests_failed;

    decimating_boxcar_filter #(.DATA_WIDTH(16), .LOG2_DECIM(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .out_ready      (out_ready),
        .buf_level      (buf_level),
        .overflow       (overflow),
        .clear_ovf      (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the next negedge, just after the accepting edge.
    task automatic drive_one(input logic signed [15:0] v);
        data_in    = v;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic run_window(input logic signed [15:0] first, input logic signed [15:0] rest);
        drive_one(first);
        repeat (7) drive_one(rest);
    endtask

    task automatic test_reset;
        tests_run++; if (data_out !== 16'sd0) begin tests_failed++; $display("FAIL reset_data_out: got %0d expected 0", data_out); end
        tests_run++; if (data_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", data_out_valid); end
        tests_run++; if (buf_level !== 2'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", buf_level); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (data_out_valid !== 1'b0 || data_out !== 16'sd0) begin tests_failed++; $display("FAIL idle_after_reset: got valid=%b data=%0d expected 0/0", data_out_valid, data_out); end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_one(16'sd100);
            @(negedge clk);
        end
        tests_run++; if (data_out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %b expected 0", data_out_valid); end
        drive_one(16'sd100);
        tests_run++; if (data_out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b expected 1", data_out_valid); end
        tests_run++; if (data_out !== 16'sd100) begin tests_failed++; $display("FAIL basic_data: got %0d expected 100", data_out); end
        @(negedge clk);
        tests_run++; if (data_out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_one_cycle: got %b expected 0", data_out_valid); end
        tests_run++; if (data_out !== 16'sd100) begin tests_failed++; $display("FAIL basic_hold: got %0d expected 100", data_out); end
    endtask

    task automatic test_reset_midwindow;
        out_ready = 1'b0;
        run_window(16'sd7, 16'sd7);
        run_window(16'sd9, 16'sd9);
        tests_run++; if (buf_level !== 2'd2) begin tests_failed++; $display("FAIL rst_pre_level: got %0d expected 2", buf_level); end
        repeat (3) drive_one(16'sd1000);
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (data_out !== 16'sd0 || data_out_valid !== 1'b0 || buf_level !== 2'd0 || overflow !== 1'b0)
            begin tests_failed++; $display("FAIL rst_async: got data=%0d valid=%b level=%0d ovf=%b expected all 0", data_out, data_out_valid, buf_level, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        run_window(16'sd5, 16'sd5);
        tests_run++; if (data_out !== 16'sd5) begin tests_failed++; $display("FAIL rst_first_window: got %0d expected 5", data_out); end
        tests_run++; if (buf_level !== 2'd1) begin tests_failed++; $display("FAIL rst_first_level: got %0d expected 1", buf_level); end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rounding;
        out_ready = 1'b1;
        run_window(16'sd1, 16'sd0);
        tests_run++; if (data_out !== 16'sd0 || data_out_valid !== 1'b1) begin tests_failed++; $display("FAIL round_pos: got %0d expected 0", data_out); end
        run_window(-16'sd1, 16'sd0);
        tests_run++; if (data_out !== -16'sd1) begin tests_failed++; $display("FAIL round_neg: got %0d expected -1", data_out); end
        run_window(16'sd32767, 16'sd32767);
        tests_run++; if (data_out !== 16'sd32767) begin tests_failed++; $display("FAIL max_pos: got %0d expected 32767", data_out); end
        run_window(-16'sd32768, -16'sd32768);
        tests_run++; if (data_out !== -16'sd32768) begin tests_failed++; $display("FAIL max_neg: got %0d expected -32768", data_out); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        run_window(16'sd10, 16'sd10);
        run_window(16'sd20, 16'sd20);
        run_window(16'sd30, 16'sd30);
        tests_run++; if (buf_level !== 2'd2) begin tests_failed++; $display("FAIL bp_level: got %0d expected 2", buf_level); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        tests_run++; if (data_out !== 16'sd10) begin tests_failed++; $display("FAIL bp_head: got %0d expected 10", data_out); end
        run_window(16'sd40, 16'sd40);
        clear_ovf = 1'b1;
        run_window(16'sd50, 16'sd50);
        clear_ovf = 1'b0;
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL bp_clear_vs_drop: got %b expected 1", overflow); end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (data_out !== 16'sd20 || buf_level !== 2'd1) begin tests_failed++; $display("FAIL bp_second: got data=%0d level=%0d expected 20/1", data_out, buf_level); end
        @(negedge clk);
        tests_run++; if (data_out_valid !== 1'b0 || data_out !== 16'sd20) begin tests_failed++; $display("FAIL bp_drained: got valid=%b data=%0d expected 0/20", data_out_valid, data_out); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL bp_sticky: got %b expected 1", overflow); end
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL bp_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_pop;
        out_ready = 1'b0;
        run_window(16'sd50, 16'sd50);
        run_window(16'sd60, 16'sd60);
        repeat (7) drive_one(16'sd40);
        out_ready = 1'b1;
        drive_one(16'sd40);
        tests_run++; if (buf_level !== 2'd2 || overflow !== 1'b0) begin tests_failed++; $display("FAIL fp_level: got level=%0d ovf=%b expected 2/0", buf_level, overflow); end
        tests_run++; if (data_out !== 16'sd60) begin tests_failed++; $display("FAIL fp_head: got %0d expected 60", data_out); end
        @(negedge clk);
        tests_run++; if (data_out !== 16'sd40 || buf_level !== 2'd1) begin tests_failed++; $display("FAIL fp_last: got data=%0d level=%0d expected 40/1", data_out, buf_level); end
        @(negedge clk);
        tests_run++; if (buf_level !== 2'd0) begin tests_failed++; $display("FAIL fp_empty: got %0d expected 0", buf_level); end
    endtask

    task automatic test_enable_abort;
        out_ready = 1'b1;
        repeat (4) drive_one(16'sd1000);
        en         = 1'b0;
        data_in    = 16'sd500;
        data_valid = 1'b1;
        @(negedge clk);
        en         = 1'b1;
        data_valid = 1'b0;
        repeat (7) drive_one(-16'sd8);
        tests_run++; if (data_out_valid !== 1'b0) begin tests_failed++; $display("FAIL ab_early: got %b expected 0", data_out_valid); end
        drive_one(-16'sd8);
        tests_run++; if (data_out !== -16'sd8 || data_out_valid !== 1'b1) begin tests_failed++; $display("FAIL ab_result: got data=%0d valid=%b expected -8/1", data_out, data_out_valid); end
        @(negedge clk);
        tests_run++; if (data_out_valid !== 1'b0) begin tests_failed++; $display("FAIL ab_single: got %b expected 0", data_out_valid); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        en           = 1'b0;
        data_in      = '0;
        data_valid   = 1'b0;
        out_ready    = 1'b0;
        clear_ovf    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_basic;
        test_reset_midwindow;
        test_rounding;
        test_backpressure;
        test_full_pop;
        test_enable_abort;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
